// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester bus arbiter: control/status bit
// positions, FSM state encoding and small word-building helpers.
package bus_arbiter_pkg;

  localparam int CTRL_READ  = 0;
  localparam int CTRL_WRITE = 1;
  localparam int STAT_ACK   = 0;
  localparam int STAT_ERR   = 1;

  localparam logic [31:0] STAT_OK    = 32'(1) << STAT_ACK;
  localparam logic [31:0] STAT_ABORT = STAT_OK | (32'(1) << STAT_ERR);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } arb_state_e;

  // A request with both bits set is treated as a write.
  function automatic logic [31:0] op_word(input logic is_write);
    return is_write ? (32'(1) << CTRL_WRITE) : (32'(1) << CTRL_READ);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// One request/response channel: control, address and write data flow from
// master to slave, status and read data flow back.
interface bus_arbiter_if;
  logic [31:0] ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] stat;
  logic [31:0] rdata;

  modport master (output ctrl, addr, wdata, input  stat, rdata);
  modport slave  (input  ctrl, addr, wdata, output stat, rdata);
endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way winner selection: round-robin against the last-served requester,
// or fixed priority with m0 winning when rr_en is low.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr_en && !last) ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two requesters onto a single device port with a four-state FSM,
// an ACK timeout and registered outputs on every port.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter bit RR_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  m0,
  bus_arbiter_if.slave  m1,
  bus_arbiter_if.master dev,
  output logic [1:0]    grant
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_e  state;
  logic        last;  // 1 when m1 was served most recently
  logic [7:0]  tmo_cnt;
  logic [31:0] op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  req;
  logic [1:0]  pick;
  logic        dev_ack;
  logic        win_busy;
  logic        unused_bits;

  assign req = {m1.ctrl[CTRL_READ] | m1.ctrl[CTRL_WRITE],
                m0.ctrl[CTRL_READ] | m0.ctrl[CTRL_WRITE]};
  assign dev_ack     = dev.stat[STAT_ACK];
  assign win_busy    = grant[1] ? req[1] : req[0];
  assign unused_bits = ^{m0.ctrl, m1.ctrl, dev.stat};

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .rr_en(RR_EN),
    .gnt  (pick)
  );

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      tmo_cnt   <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      grant     <= '0;
      dev.ctrl  <= '0;
      dev.addr  <= '0;
      dev.wdata <= '0;
      m0.stat   <= '0;
      m0.rdata  <= '0;
      m1.stat   <= '0;
      m1.rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant   <= pick;
            op_q    <= op_word(pick[1] ? m1.ctrl[CTRL_WRITE] : m0.ctrl[CTRL_WRITE]);
            addr_q  <= pick[1] ? m1.addr  : m0.addr;
            wdata_q <= pick[1] ? m1.wdata : m0.wdata;
            state   <= ISSUE;
          end
        end

        // Hold off while a stale ACK from an earlier transaction is still up.
        ISSUE: begin
          if (!dev_ack) begin
            dev.ctrl  <= op_q;
            dev.addr  <= addr_q;
            dev.wdata <= wdata_q;
            tmo_cnt   <= '0;
            state     <= WAIT_ACK;
          end
        end

        // ACK is tested before expiry, so an ACK on the last cycle succeeds.
        WAIT_ACK: begin
          if (dev_ack) begin
            dev.ctrl <= '0;
            if (grant[1]) begin
              m1.stat <= STAT_OK;
              if (op_q[CTRL_READ]) m1.rdata <= dev.rdata;
            end else begin
              m0.stat <= STAT_OK;
              if (op_q[CTRL_READ]) m0.rdata <= dev.rdata;
            end
            state <= RELEASE;
          end else if (tmo_cnt >= TMO_LAST) begin
            dev.ctrl <= '0;
            if (grant[1]) m1.stat <= STAT_ABORT;
            else          m0.stat <= STAT_ABORT;
            state <= RELEASE;
          end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RELEASE: begin
          if (!win_busy && !dev_ack) begin
            m0.stat <= '0;
            m1.stat <= '0;
            grant   <= '0;
            last    <= grant[1];
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
